// File: rtl/shared_timer_arbiter.sv
// Four requesters share one interval counter; a round-robin arbiter grants it
// for dur+1 cycles, pulsing done on completion, or releases it early on request drop.
module shared_timer_arbiter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     i_req,
    input  logic [4*W-1:0] i_dur,
    output logic [3:0]     o_gnt,
    output logic [3:0]     o_done,
    output logic           o_busy,
    output logic [W-1:0]   o_q
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_sel;
    logic [1:0]     r_ptr;
    logic [W-1:0]   r_durL;
    logic [W-1:0]   r_q;
    logic [1:0]     w_pick;
    logic           w_found;
    logic [W-1:0]   w_durSel;
    logic [3:0]     w_selOh;
    logic           w_atEnd;
    logic           w_start;
    logic           w_exit;

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        w_pick  = r_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && i_req[r_ptr + 2'(k)]) begin
                w_pick  = r_ptr + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        case (w_pick)
            2'd0:    w_durSel = i_dur[W-1:0];
            2'd1:    w_durSel = i_dur[2*W-1:W];
            2'd2:    w_durSel = i_dur[3*W-1:2*W];
            default: w_durSel = i_dur[4*W-1:3*W];
        endcase
    end

    assign w_selOh = 4'b0001 << r_sel;
    assign w_atEnd = (r_q == r_durL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Completion is tested before the abort so a simultaneous drop still gets done.
    always_comb begin
        w_next  = r_state;
        o_gnt   = 4'b0000;
        o_done  = 4'b0000;
        o_busy  = 1'b0;
        o_q     = '0;
        w_start = 1'b0;
        w_exit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_next  = COUNT;
                    w_start = 1'b1;
                end
            end
            COUNT: begin
                o_gnt  = w_selOh;
                o_busy = 1'b1;
                o_q    = r_q;
                if (w_atEnd) begin
                    o_done = w_selOh;
                    w_next = IDLE;
                    w_exit = 1'b1;
                end else if (!i_req[r_sel]) begin
                    w_next = IDLE;
                    w_exit = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= 2'd0;
            r_ptr  <= 2'd3;
            r_durL <= '0;
            r_q    <= '0;
        end else if (w_start) begin
            r_sel  <= w_pick;
            r_durL <= w_durSel;
            r_q    <= '0;
        end else if (w_exit) begin
            r_ptr  <= r_sel;
            r_q    <= '0;
        end else if (r_state == COUNT) begin
            r_q    <= r_q + 1'b1;
        end
    end

endmodule
